// File: rtl/arm_fetch_if.sv
// rtl/arm_fetch_if.sv - instruction memory read port between arm_fetch and imem
interface arm_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata, imem_err);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata, imem_err);
endinterface

// File: rtl/arm_fetch.sv
// rtl/arm_fetch.sv - fetch stage: single-outstanding imem reads, output reg + 1-entry skid, PC redirect
module arm_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    arm_fetch_if.master imem,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc8,
    output logic        inst_abort
);

    typedef enum logic [1:0] {ST_START, ST_REQ, ST_HOLD, ST_DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic        out_v, out_v_nxt;
    logic [31:0] out_inst, out_inst_nxt;
    logic [31:0] out_pc, out_pc_nxt;
    logic        out_abort, out_abort_nxt;
    logic        skid_v, skid_v_nxt;
    logic [31:0] skid_inst, skid_inst_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic        skid_abort, skid_abort_nxt;

    logic        consume;
    logic [31:0] fetch_pc_inc;
    logic [31:0] redirect_aligned;

    assign consume          = out_v & ~stall;
    assign fetch_pc_inc     = fetch_pc + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_START;
            fetch_pc   <= RESET_PC;
            addr_q     <= RESET_PC;
            out_v      <= 1'b0;
            out_inst   <= 32'h0;
            out_pc     <= 32'h0;
            out_abort  <= 1'b0;
            skid_v     <= 1'b0;
            skid_inst  <= 32'h0;
            skid_pc    <= 32'h0;
            skid_abort <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            addr_q     <= addr_nxt;
            out_v      <= out_v_nxt;
            out_inst   <= out_inst_nxt;
            out_pc     <= out_pc_nxt;
            out_abort  <= out_abort_nxt;
            skid_v     <= skid_v_nxt;
            skid_inst  <= skid_inst_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_abort <= skid_abort_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        addr_nxt       = addr_q;
        out_v_nxt      = out_v;
        out_inst_nxt   = out_inst;
        out_pc_nxt     = out_pc;
        out_abort_nxt  = out_abort;
        skid_v_nxt     = skid_v;
        skid_inst_nxt  = skid_inst;
        skid_pc_nxt    = skid_pc;
        skid_abort_nxt = skid_abort;

        if (consume) begin
            out_v_nxt = 1'b0;
        end

        if (redirect) begin
            // A read already issued for the old stream must still complete before the new one starts
            fetch_pc_nxt = redirect_aligned;
            out_v_nxt    = 1'b0;
            skid_v_nxt   = 1'b0;
            case (state)
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        addr_nxt = redirect_aligned;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: state_nxt = ST_DRAIN;
                default: begin
                    state_nxt = ST_REQ;
                    addr_nxt  = redirect_aligned;
                end
            endcase
        end else begin
            case (state)
                ST_START: begin
                    state_nxt = ST_REQ;
                    addr_nxt  = fetch_pc;
                end
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        fetch_pc_nxt = fetch_pc_inc;
                        if (!out_v || consume) begin
                            out_v_nxt     = 1'b1;
                            out_inst_nxt  = imem.imem_rdata;
                            out_pc_nxt    = addr_q;
                            out_abort_nxt = imem.imem_err;
                            addr_nxt      = fetch_pc_inc;
                        end else begin
                            skid_v_nxt     = 1'b1;
                            skid_inst_nxt  = imem.imem_rdata;
                            skid_pc_nxt    = addr_q;
                            skid_abort_nxt = imem.imem_err;
                            state_nxt      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        out_v_nxt     = 1'b1;
                        out_inst_nxt  = skid_inst;
                        out_pc_nxt    = skid_pc;
                        out_abort_nxt = skid_abort;
                        skid_v_nxt    = 1'b0;
                        state_nxt     = ST_REQ;
                        addr_nxt      = fetch_pc;
                    end
                end
                ST_DRAIN: begin
                    if (imem.imem_ack) begin
                        state_nxt = ST_REQ;
                        addr_nxt  = fetch_pc;
                    end
                end
            endcase
        end
    end

    assign imem.imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    assign imem.imem_addr = addr_q;
    assign inst_valid     = out_v;
    assign inst_out       = out_inst;
    assign inst_pc        = out_pc;
    assign inst_pc8       = out_pc + 32'd8;
    assign inst_abort     = out_abort;

endmodule

// File: tb/tb_arm_fetch.sv
// tb/tb_arm_fetch.sv - scoreboard bench for arm_fetch with a randomized memory and decode
module tb_arm_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc8;
    logic        inst_abort;

    always #5 clk = ~clk;

    arm_fetch_if imem ();

    arm_fetch #(.RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .inst_pc8    (inst_pc8),
        .inst_abort  (inst_abort)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        abort;
    } exp_t;

    exp_t        exp_q[$];
    int          pass_cnt = 0;
    int          chk_cnt = 0;
    int          xfer_cnt = 0;
    int          max_delay = 0;
    int          err_pct = 0;
    int          wait_cnt = 0;
    int          hold_left = 0;
    logic [31:0] hold_addr = 32'h1;
    logic [31:0] err_addr = 32'h1;
    logic [31:0] model_fetch = 32'h0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    bit          abort_seen = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called 2ns after a rising edge: plays memory and execute for the next edge and
    // records which words decode must eventually see, in address order.
    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt);
        logic        ack;
        logic [31:0] t;
        if (prev_req && !prev_ack)
            chk(imem.imem_addr == prev_addr, "addr_stable", {32'h0, imem.imem_addr}, {32'h0, prev_addr});
        ack = 1'b0;
        if (imem.imem_req) begin
            if (hold_left > 0 && imem.imem_addr == hold_addr) hold_left--;
            else if (wait_cnt == 0) begin
                ack = 1'b1;
                wait_cnt = $urandom_range(0, max_delay);
            end else wait_cnt--;
        end
        imem.imem_ack   = ack;
        imem.imem_rdata = $urandom;
        imem.imem_err   = ack && (imem.imem_addr == err_addr || $urandom_range(0, 99) < err_pct);
        t = tgt;
        if (rd && imem.imem_req && (t & ~32'h3) == imem.imem_addr) t = t ^ 32'h0000_1000;
        stall       = st;
        redirect    = rd;
        redirect_pc = t;
        if (rd) begin
            exp_q.delete();
            model_fetch = t & ~32'h3;
        end else if (ack && imem.imem_addr == model_fetch) begin
            exp_q.push_back('{pc: imem.imem_addr, data: imem.imem_rdata, abort: imem.imem_err});
            model_fetch = model_fetch + 32'd4;
        end
        prev_req  = imem.imem_req;
        prev_ack  = ack;
        prev_addr = imem.imem_addr;
    endtask

    // Monitor: decode side, compares every transfer against the scoreboard
    initial begin
        exp_t        e;
        logic        hv_prev = 1'b0;
        logic        rd_prev = 1'b0;
        logic [31:0] h_out = 32'h0;
        logic [31:0] h_pc = 32'h0;
        logic        h_ab = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hv_prev = 1'b0;
                rd_prev = 1'b0;
            end else begin
                if (hv_prev)
                    chk(inst_valid && inst_out == h_out && inst_pc == h_pc && inst_abort == h_ab,
                        "stall_hold", {inst_pc, inst_out}, {h_pc, h_out});
                if (rd_prev)
                    chk(!inst_valid, "redirect_flush", {63'h0, inst_valid}, 64'h0);
                if (inst_valid && !stall && !redirect) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_inst", {inst_pc, inst_out}, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(inst_pc == e.pc && inst_out == e.data && inst_abort == e.abort &&
                            inst_pc8 == e.pc + 32'd8, "inst", {inst_pc, inst_out}, {e.pc, e.data});
                        if (e.abort && e.pc == 32'h20) abort_seen = 1'b1;
                        xfer_cnt++;
                    end
                end
                hv_prev = inst_valid && stall && !redirect;
                h_out   = inst_out;
                h_pc    = inst_pc;
                h_ab    = inst_abort;
                rd_prev = redirect;
            end
        end
    end

    initial begin
        int          n;
        int          xs;
        logic [31:0] tgt;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        imem.imem_err   = 1'b0;

        // Reset and first request
        repeat (3) tick();
        chk(!imem.imem_req, "reset_req", {63'h0, imem.imem_req}, 64'h0);
        chk(!inst_valid, "reset_valid", {63'h0, inst_valid}, 64'h0);
        chk(imem.imem_addr == 32'h0, "reset_addr", {32'h0, imem.imem_addr}, 64'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk(imem.imem_req && imem.imem_addr == 32'h0, "start_req", {31'h0, imem.imem_req, imem.imem_addr}, {31'h0, 1'b1, 32'h0});

        // Redirect while the read of 0x10 is held off by memory
        hold_addr = 32'h10;
        hold_left = 3;
        n = 0;
        while (!(imem.imem_req && imem.imem_addr == 32'h10) && n < 40) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
            n++;
        end
        chk(n < 40, "reach_0x10", {32'h0, imem.imem_addr}, 64'h10);
        drive(1'b0, 1'b1, 32'h103);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(imem.imem_req && imem.imem_addr == 32'h10, "drain_addr", {32'h0, imem.imem_addr}, 64'h10);
            chk(!inst_valid, "drain_no_valid", {63'h0, inst_valid}, 64'h0);
            drive(1'b0, 1'b0, 32'h0);
        end
        tick();
        chk(imem.imem_req && imem.imem_addr == 32'h100, "redirect_addr", {32'h0, imem.imem_addr}, 64'h100);

        // Zero-wait streaming: one instruction per cycle
        xs = xfer_cnt;
        repeat (30) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        chk(xfer_cnt - xs >= 28, "stream_rate", 64'(xfer_cnt - xs), 64'd28);

        // Stall fills the skid then stops requesting
        repeat (5) begin
            drive(1'b1, 1'b0, 32'h0);
            tick();
        end
        chk(!imem.imem_req, "stall_req_off", {63'h0, imem.imem_req}, 64'h0);
        chk(inst_valid, "stall_valid", {63'h0, inst_valid}, 64'h1);
        repeat (4) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end

        // Redirect coinciding with an ack, then redirect while stalled with skid full
        drive(1'b0, 1'b1, 32'h200);
        tick();
        repeat (4) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        repeat (3) begin
            drive(1'b1, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h300);
        tick();
        repeat (5) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end

        // Wrap past the top of memory and a faulting fetch at 0x20
        err_addr = 32'h20;
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk(imem.imem_addr == 32'hFFFF_FFFC, "wrap_first", {32'h0, imem.imem_addr}, 64'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk(imem.imem_addr == 32'h0, "wrap_addr", {32'h0, imem.imem_addr}, 64'h0);
        repeat (14) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        chk(abort_seen, "abort_0x20", {63'h0, abort_seen}, 64'h1);
        err_addr = 32'h1;

        // Randomized memory latency, stalls, faults and redirects
        max_delay = 3;
        err_pct   = 10;
        repeat (600) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, tgt);
            tick();
        end

        // Asynchronous reset in the middle of traffic
        rst_n = 1'b0;
        #1;
        chk(!imem.imem_req, "async_rst_req", {63'h0, imem.imem_req}, 64'h0);
        chk(!inst_valid, "async_rst_valid", {63'h0, inst_valid}, 64'h0);
        imem.imem_ack = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        exp_q.delete();
        model_fetch = 32'h0;
        wait_cnt    = 0;
        hold_left   = 0;
        prev_req    = 1'b0;
        max_delay   = 0;
        err_pct     = 0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk(imem.imem_req && imem.imem_addr == 32'h0, "restart_req", {32'h0, imem.imem_addr}, 64'h0);

        // Final streaming: throughput and bounded buffering
        xs = xfer_cnt;
        repeat (20) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        chk(xfer_cnt - xs >= 18, "final_rate", 64'(xfer_cnt - xs), 64'd18);
        chk(exp_q.size() <= 2, "final_backlog", 64'(exp_q.size()), 64'd2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
